// File: rtl/core_alu_serial_pkg.sv
// core_alu_serial_types
// Shared definitions for the slice-serial ALU: the opcode enum, flag bit
// positions inside the {N,V,Z,C} flag vector and per-opcode lookups.
// Ports: none (package).
package core_alu_serial_types;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_TXL = 4'd1,
        OP_TXR = 4'd2,
        OP_ADD = 4'd3,
        OP_SUB = 4'd4,
        OP_INC = 4'd5,
        OP_DEC = 4'd6,
        OP_CMP = 4'd7,
        OP_BIT = 4'd8,
        OP_AND = 4'd9,
        OP_OR  = 4'd10,
        OP_XOR = 4'd11,
        OP_ROL = 4'd12,
        OP_ROR = 4'd13,
        OP_ASL = 4'd14,
        OP_LSR = 4'd15
    } alu_op_t;

    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    // Which of {N,V,Z,C} an opcode is allowed to report.
    function automatic logic [3:0] flag_mask(input alu_op_t op);
        logic [3:0] m;
        m = 4'b0000;
        case (op)
            OP_ADD, OP_SUB:                          m = 4'b1111;
            OP_INC, OP_DEC, OP_TXL, OP_TXR,
            OP_AND, OP_OR, OP_XOR:                   m = 4'b1010;
            OP_CMP, OP_ROL, OP_ROR, OP_ASL, OP_LSR:  m = 4'b1011;
            OP_BIT:                                  m = 4'b1110;
            default:                                 m = 4'b0000;
        endcase
        return m;
    endfunction

    // Compare-style opcodes only produce flags, never a write-back.
    function automatic logic write_en(input alu_op_t op);
        return !(op == OP_NOP || op == OP_CMP || op == OP_BIT);
    endfunction

    // Value injected into the carry/shift chain before the first slice.
    function automatic logic chain_init(input alu_op_t op, input logic cin);
        logic c;
        c = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ROL, OP_ROR: c = cin;
            OP_INC, OP_CMP:                 c = 1'b1;
            default:                        c = 1'b0;
        endcase
        return c;
    endfunction

    // Right shifts walk from the top slice down so the shift-in bit can
    // travel toward bit 0.
    function automatic logic msb_first(input alu_op_t op);
        return (op == OP_ROR || op == OP_LSR);
    endfunction

endpackage

// File: rtl/core_alu_serial_slice.sv
// core_alu_slice
// Combinational SLICE-bit ALU slice. The chain carries the arithmetic carry
// upward, the left-shift bit upward, or the right-shift bit downward.
// Ports:
//   op            opcode of the running operation
//   lhs, rhs      operand bits of this slice
//   chain_in      carry / shift bit arriving from the previous slice
//   is_msb_slice  this slice holds the operand MSB
//   res           result bits of this slice
//   chain_out     carry / shift bit leaving toward the next slice
//   zero          slice result is zero (lhs&rhs for BIT)
//   v_cand        signed overflow, meaningful only on the MSB slice
module core_alu_slice
    import core_alu_serial_types::*;
#(
    parameter int SLICE = 8
) (
    input  alu_op_t          op,
    input  logic [SLICE-1:0] lhs,
    input  logic [SLICE-1:0] rhs,
    input  logic             chain_in,
    input  logic             is_msb_slice,
    output logic [SLICE-1:0] res,
    output logic             chain_out,
    output logic             zero,
    output logic             v_cand
);

    logic [SLICE-1:0] erhs;
    logic [SLICE:0]   sum;
    logic [SLICE:0]   shl;
    logic [SLICE:0]   shr;
    logic             arith;

    // Effective right operand: subtraction-like ops feed the adder with the
    // complement and rely on the chain seed for the +1.
    always_comb begin
        erhs  = rhs;
        arith = 1'b1;
        case (op)
            OP_ADD:         erhs = rhs;
            OP_SUB, OP_CMP: erhs = ~rhs;
            OP_INC:         erhs = '0;
            OP_DEC:         erhs = '1;
            default: begin
                erhs  = rhs;
                arith = 1'b0;
            end
        endcase
    end

    assign sum = {1'b0, lhs} + {1'b0, erhs} + {{SLICE{1'b0}}, chain_in};
    assign shl = {lhs, chain_in};
    assign shr = {chain_in, lhs};

    // Result and outgoing chain bit per opcode.
    always_comb begin
        res       = lhs;
        chain_out = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_CMP: begin
                res       = sum[SLICE-1:0];
                chain_out = sum[SLICE];
            end
            OP_AND: res = lhs & rhs;
            OP_OR:  res = lhs | rhs;
            OP_XOR: res = lhs ^ rhs;
            OP_TXR: res = rhs;
            OP_ROL, OP_ASL: begin
                res       = shl[SLICE-1:0];
                chain_out = shl[SLICE];
            end
            OP_ROR, OP_LSR: begin
                res       = shr[SLICE:1];
                chain_out = shr[0];
            end
            default: res = lhs;
        endcase
    end

    assign zero   = (op == OP_BIT) ? ((lhs & rhs) == '0) : (res == '0);
    assign v_cand = is_msb_slice && arith &&
                    (lhs[SLICE-1] == erhs[SLICE-1]) &&
                    (sum[SLICE-1] != lhs[SLICE-1]);

endmodule

// File: rtl/core_alu_serial.sv
// core_alu_serial
// Multi-cycle ALU that processes a WIDTH-bit operation SLICE bits per clock,
// chaining carry/shift state between slices and accumulating flags.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           operation handshake
//   in_op, in_lhs, in_rhs       opcode and operands
//   in_carry                    incoming C flag
//   out_valid/out_ready         result handshake
//   out_result                  WIDTH-bit result
//   out_flags, out_flags_mask   {N,V,Z,C} and the flags the op updates
//   out_write                   result should be written back
module core_alu_serial
    import core_alu_serial_types::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_lhs,
    input  logic [WIDTH-1:0] in_rhs,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       out_flags_mask,
    output logic             out_write
);

    localparam int SLICES = WIDTH / SLICE;
    localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLICES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    if (WIDTH < 2 || (WIDTH % SLICE) != 0) begin : g_bad_params
        $error("core_alu_serial: WIDTH must be >= 2 and a multiple of SLICE");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    alu_op_t          op_q;
    logic [WIDTH-1:0] lhs_q;
    logic [WIDTH-1:0] rhs_q;
    logic             chain_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_acc;
    logic             v_acc;

    logic [CNT_W-1:0] idx;
    logic [SLICE-1:0] s_res;
    logic             s_chain;
    logic             s_zero;
    logic             s_v;
    logic             s_msb;
    logic [WIDTH-1:0] res_next;
    logic             zero_next;
    logic             v_next;
    logic             n_final;
    logic             v_final;
    logic             accept;
    alu_op_t          op_in;

    assign op_in     = alu_op_t'(in_op);
    assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Right shifts visit slices top-down, everything else bottom-up.
    assign idx   = msb_first(op_q) ? (LAST - cnt) : cnt;
    assign s_msb = (idx == LAST);

    core_alu_slice #(.SLICE(SLICE)) u_slice (
        .op           (op_q),
        .lhs          (lhs_q[idx*SLICE +: SLICE]),
        .rhs          (rhs_q[idx*SLICE +: SLICE]),
        .chain_in     (chain_q),
        .is_msb_slice (s_msb),
        .res          (s_res),
        .chain_out    (s_chain),
        .zero         (s_zero),
        .v_cand       (s_v)
    );

    // Partial result with the current slice merged in; on the last RUN
    // cycle this is the complete answer.
    always_comb begin
        res_next = res_q;
        res_next[idx*SLICE +: SLICE] = s_res;
    end

    assign zero_next = zero_acc & s_zero;
    assign v_next    = s_msb ? s_v : v_acc;
    assign n_final   = (op_q == OP_BIT) ? rhs_q[WIDTH-1] : res_next[WIDTH-1];
    assign v_final   = (op_q == OP_BIT) ? rhs_q[WIDTH-2] : v_next;

    // FSM: accept latches the whole op, RUN walks the slices, DONE holds the
    // registered outputs until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            op_q           <= OP_NOP;
            lhs_q          <= '0;
            rhs_q          <= '0;
            chain_q        <= 1'b0;
            res_q          <= '0;
            zero_acc       <= 1'b1;
            v_acc          <= 1'b0;
            out_result     <= '0;
            out_flags      <= '0;
            out_flags_mask <= '0;
            out_write      <= 1'b0;
        end else if (accept) begin
            state    <= ST_RUN;
            cnt      <= '0;
            op_q     <= op_in;
            lhs_q    <= in_lhs;
            rhs_q    <= in_rhs;
            chain_q  <= chain_init(op_in, in_carry);
            res_q    <= '0;
            zero_acc <= 1'b1;
            v_acc    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    chain_q  <= s_chain;
                    res_q    <= res_next;
                    zero_acc <= zero_next;
                    v_acc    <= v_next;
                    if (cnt == LAST) begin
                        state          <= ST_DONE;
                        out_result     <= res_next;
                        out_flags      <= {n_final, v_final, zero_next, s_chain}
                                          & flag_mask(op_q);
                        out_flags_mask <= flag_mask(op_q);
                        out_write      <= write_en(op_q);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_alu_serial.sv
// Testbench for core_alu_serial: a table of directed vectors on the
// 16/8 configuration, handshake and reset sequences, and a single-slice
// instance for the SLICES=1 latency case.
module tb_core_alu_serial;
    import core_alu_serial_types::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [15:0] in_lhs;
    logic [15:0] in_rhs;
    logic        in_carry;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  out_flags_mask;
    logic        out_write;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [3:0]  w_in_op;
    logic [15:0] w_in_lhs;
    logic [15:0] w_in_rhs;
    logic        w_in_carry;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [15:0] w_out_result;
    logic [3:0]  w_out_flags;
    logic [3:0]  w_out_flags_mask;
    logic        w_out_write;

    int n_compared;
    int n_mismatched;

    core_alu_serial #(.WIDTH(16), .SLICE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_lhs         (in_lhs),
        .in_rhs         (in_rhs),
        .in_carry       (in_carry),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_flags      (out_flags),
        .out_flags_mask (out_flags_mask),
        .out_write      (out_write)
    );

    core_alu_serial #(.WIDTH(16), .SLICE(16)) dut_wide (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (w_in_valid),
        .in_ready       (w_in_ready),
        .in_op          (w_in_op),
        .in_lhs         (w_in_lhs),
        .in_rhs         (w_in_rhs),
        .in_carry       (w_in_carry),
        .out_valid      (w_out_valid),
        .out_ready      (w_out_ready),
        .out_result     (w_out_result),
        .out_flags      (w_out_flags),
        .out_flags_mask (w_out_flags_mask),
        .out_write      (w_out_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] lhs;
        logic [15:0] rhs;
        logic        cin;
        logic [15:0] exp_result;
        logic [3:0]  exp_flags;
        logic [3:0]  exp_mask;
        logic        exp_write;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer one op to the 16/8 instance and return after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] lhs,
                                 input logic [15:0] rhs, input logic cin);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_lhs   = lhs;
        in_rhs   = rhs;
        in_carry = cin;
        #1;
        checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_lhs   = 16'hDEAD;
        in_rhs   = 16'hBEEF;
    endtask

    // Count edges from the accepting edge until out_valid; -1 on timeout.
    task automatic waitResult(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic checkResult(input string name, input logic [15:0] r,
                               input logic [3:0] f, input logic [3:0] m,
                               input logic w);
        checkOutput({name, "_result"}, {16'd0, out_result}, {16'd0, r});
        checkOutput({name, "_flags"}, {28'd0, out_flags}, {28'd0, f});
        checkOutput({name, "_mask"}, {28'd0, out_flags_mask}, {28'd0, m});
        checkOutput({name, "_write"}, {31'd0, out_write}, {31'd0, w});
    endtask

    initial begin
        int edges;
        logic [15:0] held;

        n_compared   = 0;
        n_mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 4'd0;
        in_lhs     = '0;
        in_rhs     = '0;
        in_carry   = 1'b0;
        out_ready  = 1'b0;
        w_in_valid = 1'b0;
        w_in_op    = 4'd0;
        w_in_lhs   = '0;
        w_in_rhs   = '0;
        w_in_carry = 1'b0;
        w_out_ready = 1'b0;

        //            name       op       lhs      rhs      cin  result   NVZC     mask     wr
        vecs.push_back('{"add",    OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000, 4'b1111, 1'b1});
        vecs.push_back('{"sub",    OP_SUB, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 4'b0101, 4'b1111, 1'b1});
        vecs.push_back('{"dec",    OP_DEC, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b1000, 4'b1010, 1'b1});
        vecs.push_back('{"cmp",    OP_CMP, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0011, 4'b1011, 1'b0});
        vecs.push_back('{"bit",    OP_BIT, 16'h00F0, 16'hC00F, 1'b0, 16'h00F0, 4'b1110, 4'b1110, 1'b0});
        vecs.push_back('{"lsr",    OP_LSR, 16'h8001, 16'h0000, 1'b1, 16'h4000, 4'b0001, 4'b1011, 1'b1});
        vecs.push_back('{"ror",    OP_ROR, 16'h0002, 16'h0000, 1'b1, 16'h8001, 4'b1000, 4'b1011, 1'b1});
        vecs.push_back('{"rol",    OP_ROL, 16'h8000, 16'h0000, 1'b0, 16'h0000, 4'b0011, 4'b1011, 1'b1});
        vecs.push_back('{"asl",    OP_ASL, 16'hC001, 16'h0000, 1'b1, 16'h8002, 4'b1001, 4'b1011, 1'b1});
        vecs.push_back('{"inc",    OP_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b0010, 4'b1010, 1'b1});
        vecs.push_back('{"add_v",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100, 4'b1111, 1'b1});
        vecs.push_back('{"add_ci", OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0011, 4'b1111, 1'b1});
        vecs.push_back('{"sub_b",  OP_SUB, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b1000, 4'b1111, 1'b1});
        vecs.push_back('{"and",    OP_AND, 16'hF0F0, 16'h0FF0, 1'b0, 16'h00F0, 4'b0000, 4'b1010, 1'b1});
        vecs.push_back('{"or",     OP_OR,  16'h8000, 16'h0001, 1'b0, 16'h8001, 4'b1000, 4'b1010, 1'b1});
        vecs.push_back('{"xor",    OP_XOR, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 4'b0010, 4'b1010, 1'b1});
        vecs.push_back('{"txr",    OP_TXR, 16'h5555, 16'h1234, 1'b0, 16'h1234, 4'b0000, 4'b1010, 1'b1});
        vecs.push_back('{"txl",    OP_TXL, 16'h8765, 16'h1234, 1'b0, 16'h8765, 4'b1000, 4'b1010, 1'b1});
        vecs.push_back('{"nop",    OP_NOP, 16'h5555, 16'h1234, 1'b1, 16'h5555, 4'b0000, 4'b0000, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", {16'd0, out_result}, 32'd0);
        checkOutput("reset_flags", {28'd0, out_flags}, 32'd0);
        checkOutput("reset_mask", {28'd0, out_flags_mask}, 32'd0);
        checkOutput("reset_write", {31'd0, out_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);

        // Table of single operations, each drained before the next.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].lhs, vecs[i].rhs, vecs[i].cin);
            waitResult(edges);
            checkOutput({vecs[i].name, "_latency"}, edges, 32'd2);
            checkResult(vecs[i].name, vecs[i].exp_result, vecs[i].exp_flags,
                        vecs[i].exp_mask, vecs[i].exp_write);
            drain();
        end

        // Consumer stalls for 5 cycles; outputs must hold, no new op taken.
        applyStimulus(OP_ADD, 16'h0001, 16'h0001, 1'b0);
        waitResult(edges);
        checkOutput("stall_latency", edges, 32'd2);
        held = out_result;
        checkOutput("stall_first_result", {16'd0, held}, 32'h0002);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("stall_result_held", {16'd0, out_result}, 32'h0002);
        end

        // Back-to-back: take the result and a new op on the same edge.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = OP_SUB;
        in_lhs    = 16'h0010;
        in_rhs    = 16'h0001;
        in_carry  = 1'b1;
        #1;
        checkOutput("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_out_valid_drop", {31'd0, out_valid}, 32'd0);
        waitResult(edges);
        checkOutput("b2b_latency", edges, 32'd2);
        checkResult("b2b", 16'h000F, 4'b0001, 4'b1111, 1'b1);
        drain();

        // Reset in the middle of RUN aborts the op and clears the outputs.
        applyStimulus(OP_ADD, 16'h1111, 16'h2222, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_result", {16'd0, out_result}, 32'd0);
        checkOutput("rst_mid_flags", {28'd0, out_flags}, 32'd0);
        checkOutput("rst_mid_mask", {28'd0, out_flags_mask}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst_mid_no_result", {31'd0, out_valid}, 32'd0);

        // Single-slice configuration: result one edge after acceptance.
        @(negedge clk);
        w_in_valid = 1'b1;
        w_in_op    = OP_ADD;
        w_in_lhs   = 16'hFFFF;
        w_in_rhs   = 16'h0001;
        w_in_carry = 1'b0;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        edges = -1;
        if (w_out_valid) begin
            edges = 0;
        end else begin
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk);
                #1;
                if (w_out_valid) begin
                    edges = i;
                    break;
                end
            end
        end
        checkOutput("wide_latency", edges, 32'd1);
        checkOutput("wide_result", {16'd0, w_out_result}, 32'h0000);
        checkOutput("wide_flags", {28'd0, w_out_flags}, 32'b0011);
        checkOutput("wide_mask", {28'd0, w_out_flags_mask}, 32'b1111);
        checkOutput("wide_write", {31'd0, w_out_write}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
